brg_slave_xcel_gcd_array: RTL and testbench

//  Parametrised slave-only GCD accelerator array on a manycore tile. Connects directly to the slave

---
 rtl/brg_slave_xcel_gcd_array.sv | 226 ++++++++++++++++++++++
 tb/tb_brg_slave_xcel_gcd_array.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/brg_slave_xcel_gcd_array.sv
// brg_slave_xcel_gcd_array
// Slave-only array of num_units_p iterative GCD engines for a manycore tile.
// It sits on the slave side of the endpoint and exposes one 8-register CSR
// bank per unit. Each bank holds OPA, OPB, GO, RESULT, STATUS, CYCLES and ID.
//
// Ports
//   clk_i, reset_i     clock; asynchronous active-high reset
//   in_v_i/in_yumi_o   request handshake; every valid request is accepted at once
//   in_addr_i          word address: [2:0] selects the register, [3 +: lg_units_lp] the unit
//   in_data_i/mask_i   write data and byte mask
//   in_we_i            1 = write, 0 = read
//   returning_v_o      registered response valid, one cycle after each accepted request
//   returning_data_o   registered read data; 0 for writes
//
// Optional feature macro: BRG_XCEL_GCD_PERF_EN adds a saturating 32-bit
// per-unit CYCLES counter. Without it, CYCLES reads return 0.
module brg_slave_xcel_gcd_array #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int num_units_p  = 4,
  parameter int op_width_p   = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      in_v_i,
  input  logic [addr_width_p-1:0]   in_addr_i,
  input  logic [data_width_p-1:0]   in_data_i,
  input  logic [data_width_p/8-1:0] in_mask_i,
  input  logic                      in_we_i,
  output logic                      in_yumi_o,
  output logic                      returning_v_o,
  output logic [data_width_p-1:0]   returning_data_o
);

  localparam int lg_units_lp = (num_units_p == 1) ? 1 : $clog2(num_units_p);
  localparam logic [2:0] reg_opa_lp    = 3'd0;
  localparam logic [2:0] reg_opb_lp    = 3'd1;
  localparam logic [2:0] reg_go_lp     = 3'd2;
  localparam logic [2:0] reg_result_lp = 3'd3;
  localparam logic [2:0] reg_status_lp = 3'd4;
  localparam logic [2:0] reg_cycles_lp = 3'd5;
  localparam logic [2:0] reg_id_lp     = 3'd6;
  localparam logic [31:0] id_value_lp  = {16'(num_units_p), 16'(op_width_p)};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  logic [2:0]             reg_sel;
  logic [lg_units_lp-1:0] unit_sel;
  logic                   unit_hit;
  logic                   unused_addr;

  state_e                state_q  [num_units_p];
  state_e                state_d  [num_units_p];
  logic [op_width_p-1:0] opa_q    [num_units_p];
  logic [op_width_p-1:0] opa_d    [num_units_p];
  logic [op_width_p-1:0] opb_q    [num_units_p];
  logic [op_width_p-1:0] opb_d    [num_units_p];
  logic [op_width_p-1:0] a_q      [num_units_p];
  logic [op_width_p-1:0] a_d      [num_units_p];
  logic [op_width_p-1:0] b_q      [num_units_p];
  logic [op_width_p-1:0] b_d      [num_units_p];
  logic [op_width_p-1:0] result_q [num_units_p];
  logic [op_width_p-1:0] result_d [num_units_p];
  logic                  done_q   [num_units_p];
  logic                  done_d   [num_units_p];
  logic                  err_q    [num_units_p];
  logic                  err_d    [num_units_p];
`ifdef BRG_XCEL_GCD_PERF_EN
  logic [31:0]           cycles_q [num_units_p];
  logic [31:0]           cycles_d [num_units_p];
`endif

  logic                    returning_v_q, returning_v_d;
  logic [data_width_p-1:0] returning_data_q, returning_data_d;
  logic [data_width_p-1:0] read_data;

  // Address bits above the unit field are deliberately ignored.
  assign reg_sel     = in_addr_i[2:0];
  assign unit_sel    = in_addr_i[3 +: lg_units_lp];
  assign unit_hit    = (32'(unit_sel) < 32'(num_units_p));
  assign unused_addr = ^in_addr_i;

  assign in_yumi_o        = in_v_i;
  assign returning_v_o    = returning_v_q;
  assign returning_data_o = returning_data_q;

  // Byte-masked merge of the write data into a zero-extended operand,
  // then truncated back down to the operand width.
  function automatic logic [op_width_p-1:0] merge_bytes(
    input logic [op_width_p-1:0]     old_val,
    input logic [data_width_p-1:0]   wdata,
    input logic [data_width_p/8-1:0] wmask
  );
    logic [data_width_p-1:0] full;
    full = data_width_p'(old_val);
    for (int i = 0; i < data_width_p/8; i++) begin
      if (wmask[i]) full[8*i +: 8] = wdata[8*i +: 8];
    end
    return full[op_width_p-1:0];
  endfunction

  // CSR side effects and the per-unit engine step.
  // The RESULT-read clear of done is applied before the FSM update. This way,
  // a unit finishing in the same cycle keeps done set.
  always_comb begin
    logic sel_w, wr_w, rd_w, go_w;
    sel_w = 1'b0;
    wr_w  = 1'b0;
    rd_w  = 1'b0;
    go_w  = 1'b0;
    for (int u = 0; u < num_units_p; u++) begin
      state_d[u]  = state_q[u];
      opa_d[u]    = opa_q[u];
      opb_d[u]    = opb_q[u];
      a_d[u]      = a_q[u];
      b_d[u]      = b_q[u];
      result_d[u] = result_q[u];
      done_d[u]   = done_q[u];
      err_d[u]    = err_q[u];
`ifdef BRG_XCEL_GCD_PERF_EN
      cycles_d[u] = cycles_q[u];
`endif
      sel_w = in_v_i && unit_hit && (unit_sel == lg_units_lp'(u));
      wr_w  = sel_w && in_we_i;
      rd_w  = sel_w && !in_we_i;
      go_w  = wr_w && (reg_sel == reg_go_lp) && (in_mask_i != '0);

      if (wr_w && reg_sel == reg_opa_lp) opa_d[u] = merge_bytes(opa_q[u], in_data_i, in_mask_i);
      if (wr_w && reg_sel == reg_opb_lp) opb_d[u] = merge_bytes(opb_q[u], in_data_i, in_mask_i);
      if (wr_w && reg_sel == reg_status_lp) err_d[u] = 1'b0;
      if (rd_w && reg_sel == reg_result_lp) done_d[u] = 1'b0;

      case (state_q[u])
        IDLE, DONE: begin
          if (go_w) begin
            state_d[u] = CALC;
            a_d[u]     = opa_q[u];
            b_d[u]     = opb_q[u];
            done_d[u]  = 1'b0;
`ifdef BRG_XCEL_GCD_PERF_EN
            cycles_d[u] = '0;
`endif
          end
        end
        CALC: begin
          if (go_w) err_d[u] = 1'b1;
`ifdef BRG_XCEL_GCD_PERF_EN
          if (cycles_q[u] != '1) cycles_d[u] = cycles_q[u] + 32'd1;
`endif
          if (a_q[u] < b_q[u]) begin
            a_d[u] = b_q[u];
            b_d[u] = a_q[u];
          end else if (b_q[u] != '0) begin
            a_d[u] = a_q[u] - b_q[u];
          end else begin
            result_d[u] = a_q[u];
            done_d[u]   = 1'b1;
            state_d[u]  = DONE;
          end
        end
        default: state_d[u] = IDLE;
      endcase
    end
  end

  // Read mux and response capture. Reads see pre-update register values.
  always_comb begin
    read_data = '0;
    if (unit_hit) begin
      for (int u = 0; u < num_units_p; u++) begin
        if (unit_sel == lg_units_lp'(u)) begin
          case (reg_sel)
            reg_opa_lp:    read_data = data_width_p'(opa_q[u]);
            reg_opb_lp:    read_data = data_width_p'(opb_q[u]);
            reg_result_lp: read_data = data_width_p'(result_q[u]);
            reg_status_lp: read_data = data_width_p'({err_q[u], done_q[u], state_q[u] == CALC});
`ifdef BRG_XCEL_GCD_PERF_EN
            reg_cycles_lp: read_data = data_width_p'(cycles_q[u]);
`endif
            reg_id_lp:     read_data = data_width_p'(id_value_lp);
            default:       read_data = '0;
          endcase
        end
      end
    end
    returning_v_d    = in_v_i;
    returning_data_d = (in_v_i && !in_we_i) ? read_data : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int u = 0; u < num_units_p; u++) begin
        state_q[u]  <= IDLE;
        opa_q[u]    <= '0;
        opb_q[u]    <= '0;
        a_q[u]      <= '0;
        b_q[u]      <= '0;
        result_q[u] <= '0;
        done_q[u]   <= 1'b0;
        err_q[u]    <= 1'b0;
`ifdef BRG_XCEL_GCD_PERF_EN
        cycles_q[u] <= '0;
`endif
      end
      returning_v_q    <= 1'b0;
      returning_data_q <= '0;
    end else begin
      for (int u = 0; u < num_units_p; u++) begin
        state_q[u]  <= state_d[u];
        opa_q[u]    <= opa_d[u];
        opb_q[u]    <= opb_d[u];
        a_q[u]      <= a_d[u];
        b_q[u]      <= b_d[u];
        result_q[u] <= result_d[u];
        done_q[u]   <= done_d[u];
        err_q[u]    <= err_d[u];
`ifdef BRG_XCEL_GCD_PERF_EN
        cycles_q[u] <= cycles_d[u];
`endif
      end
      returning_v_q    <= returning_v_d;
      returning_data_q <= returning_data_d;
    end
  end

endmodule

// File: tb/tb_brg_slave_xcel_gcd_array.sv
// tb_brg_slave_xcel_gcd_array
// Self-checking bench for brg_slave_xcel_gcd_array with default parameters.
// Expected values come from a reference model of the CSR rules: a byte merge
// through masks, Euclid's modulo GCD and a subtractive step count.
module tb_brg_slave_xcel_gcd_array;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        in_v_i;
  logic [31:0] in_addr_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_mask_i;
  logic        in_we_i;
  logic        in_yumi_o;
  logic        returning_v_o;
  logic [31:0] returning_data_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [31:0] opaModel [4];
  logic [31:0] opbModel [4];

  brg_slave_xcel_gcd_array dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_v_i(in_v_i), .in_addr_i(in_addr_i),
    .in_data_i(in_data_i), .in_mask_i(in_mask_i), .in_we_i(in_we_i),
    .in_yumi_o(in_yumi_o), .returning_v_o(returning_v_o),
    .returning_data_o(returning_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference GCD by Euclid's remainder method.
  function automatic logic [31:0] gcdRef(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Expected CYCLES value: one count per engine step, including the final step.
  function automatic logic [31:0] cyclesRef(input logic [31:0] a, input logic [31:0] b);
`ifdef BRG_XCEL_GCD_PERF_EN
    logic [31:0] n, t;
    n = 0;
    forever begin
      n = n + 1;
      if (a < b) begin t = a; a = b; b = t; end
      else if (b != 0) a = a - b;
      else break;
    end
    return n;
`else
    return (a & 32'h0) | (b & 32'h0);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One bus transaction. The request is issued at a falling edge and accepted at the next
  // rising edge. The registered response is sampled just after that edge.
  task automatic applyStimulus(input logic we, input int unit, input int rsel,
                               input logic [31:0] data, input logic [3:0] mask,
                               output logic [31:0] rdata);
    @(negedge clk_i);
    in_v_i = 1'b1; in_we_i = we; in_addr_i = 32'(unit * 8 + rsel);
    in_data_i = data; in_mask_i = mask;
    #1 checkOutput("yumi_follows_v", 32'(in_yumi_o), 32'd1);
    @(posedge clk_i); #1;
    in_v_i = 1'b0; in_we_i = 1'b0; in_data_i = '0; in_mask_i = '0;
    checkOutput("resp_v_after_req", 32'(returning_v_o), 32'd1);
    if (we) checkOutput("write_resp_zero", returning_data_o, 32'd0);
    rdata = returning_data_o;
  endtask

  task automatic writeReg(input int unit, input int rsel, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] dummy;
    applyStimulus(1'b1, unit, rsel, data, mask, dummy);
  endtask

  task automatic readCheck(input string tag, input int unit, input int rsel, input logic [31:0] expected);
    logic [31:0] r;
    applyStimulus(1'b0, unit, rsel, 32'd0, 4'h0, r);
    checkOutput(tag, r, expected);
  endtask

  task automatic waitDone(input int unit, input int budget);
    logic [31:0] st;
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < budget) begin
      applyStimulus(1'b0, unit, 4, 32'd0, 4'h0, st);
      seen = st[1];
      n++;
    end
    checkOutput("done_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic runGcd(input int unit, input logic [31:0] a, input logic [31:0] b);
    writeReg(unit, 0, a, 4'hF);
    writeReg(unit, 1, b, 4'hF);
    writeReg(unit, 2, 32'd1, 4'h1);
    waitDone(unit, 2000);
    readCheck("status_done", unit, 4, 32'h2);
    readCheck("result", unit, 3, gcdRef(a, b));
    readCheck("status_after_result", unit, 4, 32'h0);
    readCheck("cycles", unit, 5, cyclesRef(a, b));
  endtask

  initial begin
    logic [31:0] bm, d, x, y;
    logic [3:0]  m;
    int u, r;
    reset_i = 1'b1; in_v_i = 1'b0; in_we_i = 1'b0;
    in_addr_i = '0; in_data_i = '0; in_mask_i = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_resp_v", 32'(returning_v_o), 32'd0);
    checkOutput("reset_resp_data", returning_data_o, 32'd0);
    @(negedge clk_i) reset_i = 1'b0;
    readCheck("reset_opa", 0, 0, 32'd0);
    readCheck("reset_status", 0, 4, 32'd0);
    readCheck("id", 0, 6, 32'h0004_0010);
    readCheck("reg7_read_zero", 1, 7, 32'd0);
    writeReg(1, 7, 32'hFFFF_FFFF, 4'hF);
    readCheck("reg7_write_ignored", 1, 7, 32'd0);
    readCheck("unit5_reg7_zero", 5, 7, 32'd0);

    // Basic GCD, zero operands and operand truncation
    runGcd(0, 32'd15, 32'd5);
    runGcd(1, 32'd0, 32'd7);
    runGcd(1, 32'd0, 32'd0);
    writeReg(1, 0, 32'h0001_0012, 4'hF);
    readCheck("opa_truncated", 1, 0, 32'h0000_0012);

    // Back-to-back starts on all units, then an idle cycle
    writeReg(0, 0, 32'd48, 4'hF);  writeReg(0, 1, 32'd18, 4'hF); writeReg(0, 2, 32'd1, 4'h1);
    writeReg(1, 0, 32'd17, 4'hF);  writeReg(1, 1, 32'd5, 4'hF);  writeReg(1, 2, 32'd1, 4'h1);
    writeReg(2, 0, 32'd100, 4'hF); writeReg(2, 1, 32'd75, 4'hF); writeReg(2, 2, 32'd1, 4'h1);
    writeReg(3, 0, 32'd9, 4'hF);   writeReg(3, 1, 32'd9, 4'hF);  writeReg(3, 2, 32'd1, 4'h1);
    @(posedge clk_i); #1;
    checkOutput("idle_resp_v_low", 32'(returning_v_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      x = (i == 0) ? 32'd48 : (i == 1) ? 32'd17 : (i == 2) ? 32'd100 : 32'd9;
      y = (i == 0) ? 32'd18 : (i == 1) ? 32'd5  : (i == 2) ? 32'd75  : 32'd9;
      waitDone(i, 2000);
      readCheck("concurrent_result", i, 3, gcdRef(x, y));
    end

    // GO to a busy unit sets err and does not disturb the computation
    writeReg(3, 0, 32'd65535, 4'hF);
    writeReg(3, 1, 32'd1, 4'hF);
    writeReg(3, 2, 32'd1, 4'h1);
    writeReg(3, 2, 32'd1, 4'h1);
    readCheck("busy_go_err", 3, 4, 32'h5);
    writeReg(3, 0, 32'd7, 4'hF);
    readCheck("opa_write_during_calc", 3, 0, 32'd7);
    waitDone(3, 70000);
    readCheck("busy_status_done_err", 3, 4, 32'h6);
    readCheck("busy_result", 3, 3, 32'd1);
    readCheck("busy_cycles", 3, 5, cyclesRef(32'd65535, 32'd1));
    readCheck("err_sticky", 3, 4, 32'h4);
    writeReg(3, 4, 32'd0, 4'hF);
    readCheck("err_cleared", 3, 4, 32'h0);

    // Asynchronous reset mid-CALC drops a pending response
    writeReg(2, 0, 32'd1000, 4'hF);
    writeReg(2, 1, 32'd1, 4'hF);
    writeReg(2, 2, 32'd1, 4'h1);
    readCheck("busy_before_reset", 2, 4, 32'h1);
    @(negedge clk_i);
    in_v_i = 1'b1; in_we_i = 1'b0; in_addr_i = 32'(2 * 8); in_mask_i = 4'h0;
    @(posedge clk_i); #1;
    checkOutput("pending_resp_v", 32'(returning_v_o), 32'd1);
    checkOutput("pending_resp_data", returning_data_o, 32'd1000);
    #1 reset_i = 1'b1;
    #1;
    checkOutput("async_reset_resp_v", 32'(returning_v_o), 32'd0);
    checkOutput("async_reset_resp_data", returning_data_o, 32'd0);
    checkOutput("yumi_in_reset_high", 32'(in_yumi_o), 32'd1);
    in_v_i = 1'b0;
    #1 checkOutput("yumi_in_reset_low", 32'(in_yumi_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("reset_held_resp_v", 32'(returning_v_o), 32'd0);
    @(negedge clk_i) reset_i = 1'b0;
    readCheck("post_reset_opa", 2, 0, 32'd0);
    readCheck("post_reset_opb", 2, 1, 32'd0);
    readCheck("post_reset_result", 2, 3, 32'd0);
    readCheck("post_reset_status", 2, 4, 32'd0);
    readCheck("post_reset_cycles", 2, 5, 32'd0);
    readCheck("post_reset_status_u3", 3, 4, 32'd0);
    runGcd(2, 32'd84, 32'd36);

    // Random byte-masked operand writes checked against the merge model
    for (int i = 0; i < 4; i++) begin
      writeReg(i, 0, 32'd0, 4'hF); opaModel[i] = 32'd0;
      writeReg(i, 1, 32'd0, 4'hF); opbModel[i] = 32'd0;
    end
    for (int i = 0; i < 16; i++) begin
      u = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 1));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      bm = 32'd0;
      for (int k = 0; k < 4; k++) if (m[k]) bm = bm | (32'hFF << (8 * k));
      if (r == 0) opaModel[u] = ((opaModel[u] & ~bm) | (d & bm)) & 32'hFFFF;
      else        opbModel[u] = ((opbModel[u] & ~bm) | (d & bm)) & 32'hFFFF;
      writeReg(u, r, d, m);
      readCheck("masked_write", u, r, (r == 0) ? opaModel[u] : opbModel[u]);
    end

    // Random GCD computations on random units
    for (int i = 0; i < 12; i++) begin
      u = int'($urandom_range(0, 3));
      x = $urandom_range(0, 150);
      y = $urandom_range(0, 150);
      runGcd(u, x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
